// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - state_t     : fetch FSM state encodings (IDLE -> ISSUE -> DONE -> IDLE)
//   - NOP         : all-zero instruction word driven when nothing is issued
//   - FUNCT_*     : R-type funct field codes understood by the datapath
//   - rtype()     : helper that assembles an R-type instruction word
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Opcode 0, shamt 0: {op, rs, rt, rd, shamt, funct}
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b0, rs, rt, rd, 5'b0, funct};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction issue channel between the fetch unit (master) and the datapath
// (slave). A word moves when instr_valid and instr_ready are both high on a
// rising clock edge.
//   instruction : DATA_W  master -> slave  instruction word
//   instr_valid : 1       master -> slave  instruction holds a valid word
//   instr_ready : 1       slave -> master  datapath accepts this cycle
//   pc          : ADDR_W  master -> slave  program address of instruction
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc;

  modport master (output instruction, output instr_valid, output pc, input instr_ready);
  modport slave  (input instruction, input instr_valid, input pc, output instr_ready);
endinterface

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Program RAM: DEPTH = 1<<ADDR_W words of DATA_W bits, one synchronous write
// port and one asynchronous read port. A read of the address being written in
// the same cycle returns the incoming word (write-first bypass).
//   clk       : clock, rising edge
//   we_i      : write strobe (already qualified by the caller)
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (combinational)
// -----------------------------------------------------------------------------
module instr_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose; program contents survive
  // reset and a reset loop would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = (we_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Holds a loadable program and issues it in order over a valid/ready channel.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high; aborts a run without a done pulse
//   wr_en_i    : program RAM write strobe (honoured in IDLE only)
//   wr_addr_i  : program RAM write address
//   wr_data_i  : instruction word to store
//   start_i    : begin issuing (sampled in IDLE)
//   prog_len_i : number of words to issue, clamped to DEPTH; sampled on start
//   instr_if   : master side of the instruction channel (instruction, valid,
//                ready, pc); instruction/valid/pc are registered
//   busy_o     : high while issuing
//   done_o     : one-cycle pulse after the last word of a pass transfers
// Build option: define LOOP_EN to repeat the program until a start seen while
// issuing requests a stop at the end of the current pass.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   prog_len_i,
  instr_fetch_if.master     instr_if,
  output logic              busy_o,
  output logic              done_o
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
`ifdef LOOP_EN
  logic              stop_q, stop_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              xfer;
  logic              last_word;

  // Program may only change while nothing is being issued.
  assign mem_we = wr_en_i && (state_q == S_IDLE);

  instr_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign xfer      = valid_q && instr_if.instr_ready;
  // Compared at ADDR_W+1 bits so len==DEPTH ends at pc==DEPTH-1 without wrap.
  assign last_word = ({1'b0, pc_q} == (len_q - 1'b1));

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rd_addr = '0;
`ifdef LOOP_EN
    stop_d  = stop_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef LOOP_EN
        stop_d = 1'b0;
`endif
        if (start_i) begin
          if (prog_len_i != '0) begin
            len_d   = (prog_len_i > LEN_MAX) ? LEN_MAX : prog_len_i;
            pc_d    = '0;
            instr_d = rd_data;     // rd_addr is 0 here; bypass covers a same-cycle write
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // Prefetch the word that follows the one on the bus.
        rd_addr = last_word ? '0 : pc_q + 1'b1;
`ifdef LOOP_EN
        if (start_i) stop_d = 1'b1;
`endif
        if (xfer) begin
          if (!last_word) begin
            pc_d    = pc_q + 1'b1;
            instr_d = rd_data;
          end else begin
            done_d = 1'b1;
`ifdef LOOP_EN
            if (stop_q || start_i) begin
              valid_d = 1'b0;
              instr_d = DATA_W'(NOP);
              state_d = S_DONE;
            end else begin
              pc_d    = '0;
              instr_d = rd_data;
            end
`else
            valid_d = 1'b0;
            instr_d = DATA_W'(NOP);
            state_d = S_DONE;
`endif
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOOP_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef LOOP_EN
      stop_q  <= stop_d;
`endif
    end
  end

  assign instr_if.instruction = instr_q;
  assign instr_if.instr_valid = valid_q;
  assign instr_if.pc          = pc_q;
  assign busy_o               = (state_q == S_ISSUE);
  assign done_o               = done_q;

endmodule
